// File: rtl/counter_mod_prog_pkg.sv
`default_nettype none
// ============================================================================
// Module   : counter_pkg
// Purpose  : Shared types and constants for the programmable modulo counter.
// Contents : cnt_state_t FSM state type, wrap-count width, direction codes.
// Revision : 1.0 - initial release
// ============================================================================
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cnt_state_t;

  localparam int   WRAPCNT_W = 16;
  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;

endpackage
`default_nettype wire

// File: rtl/counter_mod_prog_sat_inc.sv
`default_nettype none
// ============================================================================
// Module   : counter_sat_inc
// Purpose  : Saturating event counter with synchronous clear.
// Ports    : clk, rst (async, active-high)
//            inc   - count one event (ignored once all ones)
//            clr   - synchronous clear, wins over inc
//            count - current value
// Revision : 1.0 - initial release
// ============================================================================
module counter_sat_inc #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + ONE;
    end
  end

endmodule
`default_nettype wire

// File: rtl/counter_mod_prog.sv
`default_nettype none
// ============================================================================
// Module   : counter_mod_prog
// Purpose  : Runtime-programmable modulo counter (range 0..term), up/down,
//            synchronous load, start/stop and one-shot operation.
// Ports    : clk, rst (async, active-high)
//            en, start, stop, oneshot, up, load - control inputs
//            din   - load value, term - terminal value
//            q     - registered count
//            tc    - combinational terminal count for cascading
//            rco   - registered one-cycle wrap pulse
//            busy  - registered, high in RUN
//            done  - registered, high in DONE
//            wraps - saturating wrap count (only with the macro below)
// Options  : COUNTER_MOD_PROG_WRAPCNT_EN adds the wraps[15:0] output.
// Revision : 1.0 - initial release
// ============================================================================
module counter_mod_prog
  import counter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic             stop,
  input  logic             oneshot,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] term,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             rco,
  output logic             busy,
  output logic             done
`ifdef COUNTER_MOD_PROG_WRAPCNT_EN
  ,
  output logic [WRAPCNT_W-1:0] wraps
`endif
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  cnt_state_t       state, state_n;
  logic [WIDTH-1:0] q_n;
  logic             rco_n;
  logic             wrap_clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      q     <= '0;
      rco   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      q     <= q_n;
      rco   <= rco_n;
      busy  <= (state_n == RUN);
      done  <= (state_n == DONE);
    end
  end

  // Priority per edge: load > stop > start > count.
  always_comb begin
    state_n  = state;
    q_n      = q;
    rco_n    = 1'b0;
    wrap_clr = 1'b0;
    if (load) begin
      q_n      = din;
      wrap_clr = 1'b1;
    end else if (stop) begin
      state_n = IDLE;
    end else if (start) begin
      state_n  = RUN;
      q_n      = (up == DIR_UP) ? '0 : term;
      wrap_clr = 1'b1;
    end else if ((state == RUN) && en) begin
      if (up == DIR_UP) begin
        // >= rather than == so a loaded value above term recovers at once.
        rco_n = (q >= term);
        q_n   = rco_n ? '0 : q + ONE;
      end else begin
        rco_n = (q == '0);
        q_n   = rco_n ? term : q - ONE;
      end
      if (rco_n && oneshot) begin
        state_n = DONE;
      end
    end
  end

  assign tc = (state == RUN) && en && ((up == DIR_UP) ? (q == term) : (q == '0));

`ifdef COUNTER_MOD_PROG_WRAPCNT_EN
  counter_sat_inc #(
    .WIDTH (WRAPCNT_W)
  ) u_wrapcnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (rco_n),
    .clr   (wrap_clr),
    .count (wraps)
  );
`else
  logic unused_wrap_clr;
  assign unused_wrap_clr = wrap_clr;
`endif

endmodule
`default_nettype wire

// File: tb/tb_counter_mod_prog.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_mod_prog
// Purpose  : Self-checking bench for counter_mod_prog (WIDTH=4 instance plus
//            a two-stage decade cascade). Honours COUNTER_MOD_PROG_WRAPCNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_counter_mod_prog;

  localparam int W    = 4;
  localparam int MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 0, start = 0, stop = 0, oneshot = 0, up = 1, load = 0;
  logic [W-1:0] din = '0, term = '0;
  logic [W-1:0] q;
  logic         tc, rco, busy, done;

  // cascade pair
  logic         c_start = 0;
  logic [W-1:0] lo_q, hi_q;
  logic         lo_tc, hi_tc, lo_rco, hi_rco, lo_busy, hi_busy, lo_done, hi_done;
  logic [W-1:0] c_term = 4'd9;
  logic [W-1:0] c_din = '0;

`ifdef COUNTER_MOD_PROG_WRAPCNT_EN
  logic [15:0] wraps, lo_wraps, hi_wraps;
`endif

  always #5 clk = ~clk;

  counter_mod_prog #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .stop(stop),
    .oneshot(oneshot), .up(up), .load(load), .din(din), .term(term),
    .q(q), .tc(tc), .rco(rco), .busy(busy), .done(done)
`ifdef COUNTER_MOD_PROG_WRAPCNT_EN
    , .wraps(wraps)
`endif
  );

  counter_mod_prog #(.WIDTH(W)) u_lo (
    .clk(clk), .rst(rst), .en(1'b1), .start(c_start), .stop(1'b0),
    .oneshot(1'b0), .up(1'b1), .load(1'b0), .din(c_din), .term(c_term),
    .q(lo_q), .tc(lo_tc), .rco(lo_rco), .busy(lo_busy), .done(lo_done)
`ifdef COUNTER_MOD_PROG_WRAPCNT_EN
    , .wraps(lo_wraps)
`endif
  );

  counter_mod_prog #(.WIDTH(W)) u_hi (
    .clk(clk), .rst(rst), .en(lo_tc), .start(c_start), .stop(1'b0),
    .oneshot(1'b0), .up(1'b1), .load(1'b0), .din(c_din), .term(c_term),
    .q(hi_q), .tc(hi_tc), .rco(hi_rco), .busy(hi_busy), .done(hi_done)
`ifdef COUNTER_MOD_PROG_WRAPCNT_EN
    , .wraps(hi_wraps)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: plain integer count plus running/finished flags.
  int m_q = 0;
  int m_rco = 0;
  int m_run = 0;
  int m_fin = 0;
  int m_wraps = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q = 0; m_rco = 0; m_run = 0; m_fin = 0; m_wraps = 0;
  endtask

  function automatic int model_tc();
    int endv;
    endv = up ? int'(term) : 0;
    return (m_run != 0 && en && m_q == endv) ? 1 : 0;
  endfunction

  task automatic model_edge();
    int t;
    t = int'(term);
    m_rco = 0;
    if (load) begin
      m_q = int'(din); m_wraps = 0;
    end else if (stop) begin
      m_run = 0; m_fin = 0;
    end else if (start) begin
      m_run = 1; m_fin = 0; m_wraps = 0;
      m_q = up ? 0 : t;
    end else if (m_run != 0 && en) begin
      if (up) begin
        if (m_q >= t) begin m_q = 0; m_rco = 1; end
        else m_q = (m_q + 1) & MASK;
      end else begin
        if (m_q == 0) begin m_q = t; m_rco = 1; end
        else m_q = m_q - 1;
      end
      if (m_rco != 0) begin
        if (m_wraps < 65535) m_wraps++;
        if (oneshot) begin m_run = 0; m_fin = 1; end
      end
    end
  endtask

  task automatic check_regs();
    chk("q", 32'(q), 32'(m_q));
    chk("rco", 32'(rco), 32'(m_rco));
    chk("busy", 32'(busy), 32'(m_run));
    chk("done", 32'(done), 32'(m_fin));
`ifdef COUNTER_MOD_PROG_WRAPCNT_EN
    chk("wraps", 32'(wraps), 32'(m_wraps));
`endif
  endtask

  // Inputs are changed at the falling edge; tc checked mid-low-phase,
  // registered outputs checked 1 time unit after the rising edge.
  task automatic tick();
    #1;
    chk("tc", 32'(tc), 32'(model_tc()));
    @(posedge clk);
    model_edge();
    #1;
    check_regs();
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1; tick(); start = 0;
  endtask

  initial begin
    // ---- reset state
    repeat (2) @(negedge clk);
    rst = 0;
    model_reset();
    #1;
    check_regs();

    // ---- up, continuous, term=4
    term = 4'd4; up = 1; oneshot = 0; en = 1;
    pulse_start();
    repeat (12) tick();

    // ---- down, one-shot, term=3, then hold in DONE
    term = 4'd3; up = 0; oneshot = 1;
    pulse_start();
    repeat (9) tick();
    oneshot = 0;

    // ---- load out-of-range value, then load+stop+start together
    term = 4'd5; up = 1;
    pulse_start();
    tick();
    din = 4'd9; load = 1; tick(); load = 0;
    tick();
    tick();
    din = 4'd7; load = 1; stop = 1; start = 1; tick();
    load = 0; stop = 0; start = 0;
    tick();

    // ---- term=0: every enabled edge wraps; en toggling holds
    term = 4'd0;
    pulse_start();
    repeat (4) tick();
    en = 0; tick();
    en = 1; tick();
    en = 0; tick(); tick();
    en = 1; tick();

    // ---- natural binary wrap with term = all ones
    term = 4'hF;
    pulse_start();
    repeat (18) tick();

    // ---- asynchronous reset between edges at q=6
    term = 4'd9; up = 1;
    pulse_start();
    repeat (6) tick();
    chk("q_before_rst", 32'(q), 32'd6);
    #2 rst = 1;
    #1;
    model_reset();
    check_regs();
    @(negedge clk);
    rst = 0;
    repeat (3) tick();

    // ---- randomized traffic
    pulse_start();
    for (int i = 0; i < 600; i++) begin
      load    = ($urandom_range(0, 19) == 0);
      stop    = ($urandom_range(0, 29) == 0);
      start   = ($urandom_range(0, 14) == 0);
      en      = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) up = ~up;
      if ($urandom_range(0, 7) == 0) oneshot = ~oneshot;
      if ($urandom_range(0, 15) == 0) term = W'($urandom_range(0, MASK));
      din = W'($urandom_range(0, MASK));
      tick();
    end
    load = 0; stop = 0; start = 0; en = 0;

    // ---- two-stage decade cascade
    c_start = 1;
    @(posedge clk); #1;
    chk("cas_start", 32'(hi_q) * 10 + 32'(lo_q), 32'd0);
    @(negedge clk);
    c_start = 0;
    for (int k = 1; k <= 105; k++) begin
      @(posedge clk); #1;
      chk("cas_count", 32'(hi_q) * 10 + 32'(lo_q), 32'(k % 100));
      if (k == 100) begin
        chk("cas_hi_rco", 32'(hi_rco), 32'd1);
`ifdef COUNTER_MOD_PROG_WRAPCNT_EN
        chk("cas_hi_wraps", 32'(hi_wraps), 32'd1);
`endif
      end
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
